// File: rtl/sap1_control_sequencer_if.sv
// sap1_control_sequencer_if: opcode/flag inputs and microcode control outputs of the SAP-1 sequencer.
interface sap1_control_sequencer_if #(parameter int OPCODE_WIDTH = 4);
  logic                    i_step_en;
  logic [OPCODE_WIDTH-1:0] i_opcode;
  logic                    i_carry;
  logic                    i_zero;
  logic                    o_pc_out;
  logic                    o_pc_inc;
  logic                    o_pc_load;
  logic                    o_mar_in;
  logic                    o_ram_out;
  logic                    o_ram_in;
  logic                    o_ir_in;
  logic                    o_ir_out;
  logic                    o_a_in;
  logic                    o_a_out;
  logic                    o_b_in;
  logic                    o_alu_out;
  logic                    o_alu_sub;
  logic                    o_out_in;
  logic                    o_halt;
  logic [2:0]              o_step;
  modport master (
    output i_step_en, i_opcode, i_carry, i_zero,
    input  o_pc_out, o_pc_inc, o_pc_load, o_mar_in, o_ram_out, o_ram_in, o_ir_in, o_ir_out,
           o_a_in, o_a_out, o_b_in, o_alu_out, o_alu_sub, o_out_in, o_halt, o_step
  );
  modport slave (
    input  i_step_en, i_opcode, i_carry, i_zero,
    output o_pc_out, o_pc_inc, o_pc_load, o_mar_in, o_ram_out, o_ram_in, o_ir_in, o_ir_out,
           o_a_in, o_a_out, o_b_in, o_alu_out, o_alu_sub, o_out_in, o_halt, o_step
  );
endinterface

// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer: 5-step SAP-1 microcode sequencer with halt latch.
// Define SAP1_CONDITIONAL_JUMP_EN to compile in JC (0111) and JZ (1000).
module sap1_control_sequencer #(parameter int OPCODE_WIDTH = 4) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  sap1_control_sequencer_if.slave bus
);
  logic [2:0] step, step_nxt;
  logic       halted, halted_nxt;
  logic [OPCODE_WIDTH-1:0] op;
  logic lda, add, sub, sta, ldi, jmp, outp, hlt, alu, mem, jump;
  logic [4:0] t;
  assign op   = bus.i_opcode;
  assign lda  = op == OPCODE_WIDTH'(4'b0000);
  assign add  = op == OPCODE_WIDTH'(4'b0001);
  assign sub  = op == OPCODE_WIDTH'(4'b0010);
  assign sta  = op == OPCODE_WIDTH'(4'b0011);
  assign ldi  = op == OPCODE_WIDTH'(4'b0101);
  assign jmp  = op == OPCODE_WIDTH'(4'b0110);
  assign outp = op == OPCODE_WIDTH'(4'b1110);
  assign hlt  = op == OPCODE_WIDTH'(4'b1111);
  assign alu  = add | sub;
  assign mem  = lda | alu | sta;
`ifdef SAP1_CONDITIONAL_JUMP_EN
  assign jump = jmp | ((op == OPCODE_WIDTH'(4'b0111)) & bus.i_carry) | ((op == OPCODE_WIDTH'(4'b1000)) & bus.i_zero);
`else
  logic unused_flags;
  assign unused_flags = bus.i_carry ^ bus.i_zero;
  assign jump = jmp;
`endif
  // One-hot T-state, forced to zero during reset and after halt so every control drops.
  assign t = {5{i_rst_n & ~halted}} & (5'd1 << step);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      step   <= 3'd0;
      halted <= 1'b0;
    end else begin
      step   <= step_nxt;
      halted <= halted_nxt;
    end
  always_comb begin
    step_nxt   = (halted || !bus.i_step_en) ? step : (step == 3'd4) ? 3'd0 : step + 3'd1;
    halted_nxt = halted | (bus.i_step_en & (step == 3'd2) & hlt);
  end
  always_comb begin
    bus.o_pc_out  = t[0];
    bus.o_mar_in  = t[0] | (t[2] & mem);
    bus.o_pc_inc  = t[1];
    bus.o_ir_in   = t[1];
    bus.o_ram_out = t[1] | (t[3] & (lda | alu));
    bus.o_ir_out  = t[2] & (mem | ldi | jump);
    bus.o_pc_load = t[2] & jump;
    bus.o_a_in    = (t[2] & ldi) | (t[3] & lda) | (t[4] & alu);
    bus.o_a_out   = (t[2] & outp) | (t[3] & sta);
    bus.o_b_in    = t[3] & alu;
    bus.o_alu_out = t[4] & alu;
    bus.o_alu_sub = t[4] & sub;
    bus.o_ram_in  = t[3] & sta;
    bus.o_out_in  = t[2] & outp;
    bus.o_halt    = halted | (t[2] & hlt);
    bus.o_step    = step;
  end
endmodule

// File: tb/tb_sap1_control_sequencer.sv
// tb_sap1_control_sequencer: directed and random checks against a per-instruction microcode table model.
module tb_sap1_control_sequencer;
  localparam logic [14:0] PC_OUT  = 15'h4000, PC_INC = 15'h2000, PC_LOAD = 15'h1000, MAR_IN = 15'h0800,
                          RAM_OUT = 15'h0400, RAM_IN = 15'h0200, IR_IN   = 15'h0100, IR_OUT = 15'h0080,
                          A_IN    = 15'h0040, A_OUT  = 15'h0020, B_IN    = 15'h0010, ALU_OUT = 15'h0008,
                          ALU_SUB = 15'h0004, OUT_IN = 15'h0002, HALT    = 15'h0001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sap1_control_sequencer_if #(.OPCODE_WIDTH(4)) bus();
  sap1_control_sequencer #(.OPCODE_WIDTH(4)) dut(.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int vectors = 0;
  int fails = 0;
  int m_step = 0;
  bit m_halt = 1'b0;
  logic [14:0] obs;
  assign obs = {bus.o_pc_out, bus.o_pc_inc, bus.o_pc_load, bus.o_mar_in, bus.o_ram_out, bus.o_ram_in,
                bus.o_ir_in, bus.o_ir_out, bus.o_a_in, bus.o_a_out, bus.o_b_in, bus.o_alu_out,
                bus.o_alu_sub, bus.o_out_in, bus.o_halt};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_step <= 0;
      m_halt <= 1'b0;
    end else if (!m_halt && bus.i_step_en) begin
      if (m_step == 2 && bus.i_opcode == 4'd15) m_halt <= 1'b1;
      m_step <= (m_step + 1) % 5;
    end
  function automatic logic [14:0] ref_ctl(int op, int s, bit c, bit z, bit rst, bit h);
    if (!rst) return 15'h0;
    if (h) return HALT;
    if (s == 0) return PC_OUT | MAR_IN;
    if (s == 1) return RAM_OUT | IR_IN | PC_INC;
    case (op)
      0:       return s == 2 ? IR_OUT | MAR_IN : s == 3 ? RAM_OUT | A_IN : 15'h0;
      1, 2:    return s == 2 ? IR_OUT | MAR_IN : s == 3 ? RAM_OUT | B_IN :
                      s == 4 ? ALU_OUT | A_IN | (op == 2 ? ALU_SUB : 15'h0) : 15'h0;
      3:       return s == 2 ? IR_OUT | MAR_IN : s == 3 ? A_OUT | RAM_IN : 15'h0;
      5:       return s == 2 ? IR_OUT | A_IN : 15'h0;
      6:       return s == 2 ? IR_OUT | PC_LOAD : 15'h0;
`ifdef SAP1_CONDITIONAL_JUMP_EN
      7:       return (s == 2 && c) ? IR_OUT | PC_LOAD : 15'h0;
      8:       return (s == 2 && z) ? IR_OUT | PC_LOAD : 15'h0;
`endif
      14:      return s == 2 ? A_OUT | OUT_IN : 15'h0;
      15:      return s == 2 ? HALT : 15'h0;
      default: return 15'h0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
    vectors++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_all(input string tag);
    int drivers;
    drivers = 32'(bus.o_pc_out) + 32'(bus.o_ram_out) + 32'(bus.o_ir_out) + 32'(bus.o_a_out) + 32'(bus.o_alu_out);
    chk({tag, "_ctl"}, obs, ref_ctl(int'(bus.i_opcode), m_step, bus.i_carry, bus.i_zero, rst_n, m_halt));
    chk({tag, "_step"}, 15'(bus.o_step), 15'(rst_n ? m_step : 0));
    chk({tag, "_onedrv"}, 15'(drivers <= 1), 15'd1);
  endtask
  task automatic tick(input bit en, input logic [3:0] op, input bit c, input bit z, input string tag);
    bus.i_step_en = en;
    bus.i_opcode  = op;
    bus.i_carry   = c;
    bus.i_zero    = z;
    #1 check_all(tag);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic goto_step(input int s, input logic [3:0] op);
    for (int i = 0; i < 6 && m_step != s; i++) tick(1'b1, op, 1'b0, 1'b0, "goto");
  endtask
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1 check_all({tag, "_in_rst"});
    chk({tag, "_rst_zero"}, obs, 15'h0);
    #1 rst_n = 1'b1;
    #1 check_all({tag, "_released"});
  endtask
  initial begin
    logic [3:0] op;
    bus.i_step_en = 1'b0;
    bus.i_opcode  = 4'd1;
    bus.i_carry   = 1'b0;
    bus.i_zero    = 1'b0;
    @(negedge clk);
    #1 check_all("reset");
    chk("reset_zero", obs, 15'h0);
    #1 rst_n = 1'b1;
    #1 chk("t0_fetch", obs, PC_OUT | MAR_IN);
    @(negedge clk);
    for (int i = 0; i < 6; i++) tick(1'b1, 4'd1, 1'b0, 1'b0, "add");
    goto_step(4, 4'd2);
    #1 chk("sub_t4", obs, ALU_OUT | A_IN | ALU_SUB);
    goto_step(2, 4'd14);
    #1 check_all("out_t2");
    chk("out_t2_word", obs, A_OUT | OUT_IN);
    goto_step(0, 4'd1);
    tick(1'b1, 4'd1, 1'b0, 1'b0, "hold0");
    tick(1'b0, 4'd1, 1'b0, 1'b0, "hold1");
    tick(1'b0, 4'd1, 1'b0, 1'b0, "hold2");
    tick(1'b1, 4'd1, 1'b0, 1'b0, "hold3");
    #1 chk("hold_step", 15'(bus.o_step), 15'd2);
    goto_step(2, 4'd15);
    for (int i = 0; i < 11; i++) tick(1'b1, 4'd15, 1'b0, 1'b0, "halt");
    #1 chk("halt_step", 15'(bus.o_step), 15'd3);
    chk("halt_word", obs, HALT);
    pulse_reset("halt_clear");
    goto_step(3, 4'd0);
    pulse_reset("lda_t3");
    chk("lda_t0_after", obs, PC_OUT | MAR_IN);
    goto_step(2, 4'd8);
    tick(1'b0, 4'd8, 1'b0, 1'b1, "jz_taken");
`ifdef SAP1_CONDITIONAL_JUMP_EN
    chk("jz_z1", 15'(bus.o_pc_load), 15'd1);
`else
    chk("jz_z1", 15'(bus.o_pc_load), 15'd0);
`endif
    tick(1'b0, 4'd8, 1'b0, 1'b0, "jz_not");
    chk("jz_z0", 15'(bus.o_pc_load), 15'd0);
    goto_step(2, 4'd7);
    tick(1'b0, 4'd7, 1'b1, 1'b0, "jc_c1");
    tick(1'b0, 4'd7, 1'b0, 1'b1, "jc_c0");
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd15 && $urandom_range(0, 7) != 0) op = 4'd14;
      if ($urandom_range(0, 39) == 0) pulse_reset("rnd_rst");
      tick($urandom_range(0, 3) != 0, op, 1'($urandom), 1'($urandom), "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/sap1_control_sequencer.md
SAP1_CONTROL_SEQUENCER -- requirements
Module: sap1_control_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 4, the width of the opcode field taken from the instruction register.
REQ-002 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_step_en  input  1  step qualifier; the step counter advances only on edges where this is high.
REQ-005 i_opcode  input  OPCODE_WIDTH  upper nibble of the instruction register.
REQ-006 i_carry  input  1  ALU carry flag, registered upstream.
REQ-007 i_zero  input  1  ALU zero flag, registered upstream.
REQ-008 o_pc_out  output  1  program counter drives the bus.
REQ-009 o_pc_inc  output  1  program counter increments.
REQ-010 o_pc_load  output  1  program counter loads from the bus.
REQ-011 o_mar_in  output  1  memory address register loads from the bus.
REQ-012 o_ram_out  output  1  RAM drives the bus.
REQ-013 o_ram_in  output  1  RAM writes from the bus.
REQ-014 o_ir_in  output  1  instruction register loads from the bus.
REQ-015 o_ir_out  output  1  instruction register operand drives the bus.
REQ-016 o_a_in / o_a_out  output  1 each  A register load / A register drives the bus.
REQ-017 o_b_in  output  1  B register loads from the bus.
REQ-018 o_alu_out / o_alu_sub  output  1 each  ALU drives the bus / ALU subtracts.
REQ-019 o_out_in  output  1  output register loads from the bus.
REQ-020 o_halt  output  1  machine halted.
REQ-021 o_step  output  3  current T-state, 0 to 4.

Function
REQ-022 SHALL hold a 3-bit step register that counts 0,1,2,3,4,0 on each i_clk edge with i_step_en=1.
- Every instruction takes exactly 5 steps.
- With i_step_en=0 the step register holds.
REQ-023 Control outputs SHALL be decoded combinationally from the step register and i_opcode; they change only when the step changes or the opcode changes.
REQ-024 Fetch steps SHALL be the same for every opcode.
- T0: pc_out, mar_in.
- T1: ram_out, ir_in, pc_inc.
REQ-025 Execute steps (T2 / T3 / T4; any unlisted step is all-zero) SHALL be:
- LDA 0000: ir_out+mar_in / ram_out+a_in / none.
- ADD 0001: ir_out+mar_in / ram_out+b_in / alu_out+a_in.
- SUB 0010: as ADD, with alu_sub also asserted at T4.
- STA 0011: ir_out+mar_in / a_out+ram_in.
- LDI 0101: ir_out+a_in.
- JMP 0110: ir_out+pc_load.
- OUT 1110: a_out+out_in.
- HLT 1111: halt.
- Every other opcode is a NOP.
REQ-026 At most one of o_pc_out, o_ram_out, o_ir_out, o_a_out, o_alu_out SHALL be high in any step (single bus driver).
REQ-027 Halt SHALL work as follows.
- A halted flag sets on the edge that leaves T2 with opcode 1111.
- Once halted, the step register freezes, all control outputs are 0 and o_halt=1, regardless of i_step_en.
- Only reset clears the halted flag.
REQ-028 o_step SHALL equal the step register at all times.

Reset
REQ-029 While i_rst_n=0, the step register SHALL be 0, the halted flag 0, all control outputs and o_halt 0, and o_step 0. Assertion at any step, including mid-instruction, takes effect immediately without waiting for a clock edge.
REQ-030 After deassertion, the first enabled edge SHALL leave T0. The T0 fetch word is visible from the deassertion.

Configuration
REQ-031 With macro SAP1_CONDITIONAL_JUMP_EN defined, conditional jumps SHALL be compiled in.
- JC 0111: T2 = ir_out+pc_load, only when i_carry=1; otherwise all-zero.
- JZ 1000: T2 = ir_out+pc_load, only when i_zero=1; otherwise all-zero.
REQ-032 With SAP1_CONDITIONAL_JUMP_EN undefined, opcodes 0111 and 1000 SHALL be NOPs, and i_carry / i_zero SHALL be ignored.

Verification
REQ-033 Reset, then i_step_en=1 with opcode 0001 -> o_step goes 0,1,2,3,4,0. T0 drives pc_out+mar_in; T3 drives ram_out+b_in; T4 drives alu_out+a_in with alu_sub=0.
REQ-034 Opcode 0010 at T4 -> alu_out=1, a_in=1, alu_sub=1. Opcode 1110 at T2 -> a_out=1, out_in=1, and no other bus driver high.
REQ-035 i_step_en toggled 1,0,0,1 from T0 -> o_step reads 1,1,1,2. Control outputs stay stable while the step holds.
REQ-036 Opcode 1111 reaches T2, then 10 enabled edges follow -> o_halt=1, o_step=3, all controls 0. Asserting i_rst_n=0 then gives o_halt=0 and o_step=0 immediately.
REQ-037 Reset asserted at T3 of LDA -> outputs go to 0 asynchronously. After release, T0 fetch is issued.
REQ-038 With SAP1_CONDITIONAL_JUMP_EN: opcode 1000 with i_zero=1 -> pc_load=1 at T2; with i_zero=0 -> pc_load=0. Without the macro: pc_load=0 in both cases.
